// File: rtl/spu32_cpu_control_pkg.sv
// Shared definitions for the spu32 control sequencer: opcodes, bus ops,
// sequencer states and the datapath select encodings.
package spu32_cpu_control_pkg;

    // RISC-V major opcodes, instr[6:2]
    localparam logic [4:0] OP_LOAD     = 5'b00000;
    localparam logic [4:0] OP_MISC_MEM = 5'b00011;
    localparam logic [4:0] OP_OPIMM    = 5'b00100;
    localparam logic [4:0] OP_AUIPC    = 5'b00101;
    localparam logic [4:0] OP_STORE    = 5'b01000;
    localparam logic [4:0] OP_OP       = 5'b01100;
    localparam logic [4:0] OP_LUI      = 5'b01101;
    localparam logic [4:0] OP_BRANCH   = 5'b11000;
    localparam logic [4:0] OP_JALR     = 5'b11001;
    localparam logic [4:0] OP_JAL      = 5'b11011;
    localparam logic [4:0] OP_SYSTEM   = 5'b11100;

    localparam logic [2:0] BUSOP_READB  = 3'b000;
    localparam logic [2:0] BUSOP_READH  = 3'b001;
    localparam logic [2:0] BUSOP_READW  = 3'b010;
    localparam logic [2:0] BUSOP_WRITEB = 3'b011;
    localparam logic [2:0] BUSOP_READBU = 3'b100;
    localparam logic [2:0] BUSOP_READHU = 3'b101;
    localparam logic [2:0] BUSOP_WRITEH = 3'b110;
    localparam logic [2:0] BUSOP_WRITEW = 3'b111;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [1:0] RDSEL_ALU = 2'd0;
    localparam logic [1:0] RDSEL_BUS = 2'd1;
    localparam logic [1:0] RDSEL_PC4 = 2'd2;

    localparam logic [1:0] PCSEL_INC = 2'd0;
    localparam logic [1:0] PCSEL_IMM = 2'd1;
    localparam logic [1:0] PCSEL_ALU = 2'd2;

    localparam logic ASEL_RS1 = 1'b0;
    localparam logic ASEL_PC  = 1'b1;
    localparam logic BSEL_RS2 = 1'b0;
    localparam logic BSEL_IMM = 1'b1;

    function automatic logic opcode_legal(input logic [4:0] opcode);
        return opcode inside {OP_LOAD, OP_MISC_MEM, OP_OPIMM, OP_AUIPC, OP_STORE,
                              OP_OP, OP_LUI, OP_BRANCH, OP_JALR, OP_JAL, OP_SYSTEM};
    endfunction

endpackage

// File: rtl/spu32_cpu_control_if.sv
// System bus request/acknowledge bundle between the control sequencer and the bus.
interface spu32_cpu_control_if;
    logic       bus_en;
    logic [2:0] bus_op;
    logic       bus_addr_sel;
    logic       bus_ack;

    modport master (output bus_en, bus_op, bus_addr_sel, input bus_ack);
    modport slave  (input bus_en, bus_op, bus_addr_sel, output bus_ack);
endinterface

// File: rtl/spu32_cpu_control_branch_eval.sv
// Branch condition evaluation: one-hot condition mask against registered ALU flags.
module spu32_cpu_branch_eval (
    input  logic [5:0] branchmask,
    input  logic       eq,
    input  logic       lt,
    input  logic       ltu,
    output logic       taken
);

    // An all-zero mask (invalid funct3) never matches
    assign taken = |(branchmask & {~ltu, ltu, ~lt, lt, ~eq, eq});

endmodule

// File: rtl/spu32_cpu_control.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer for the spu32 core,
// with a bus timeout that drops into a sticky trap state.
module spu32_cpu_control
    import spu32_cpu_control_pkg::*;
#(
    parameter int BUS_TIMEOUT = 255,
    parameter int TIMEOUT_W   = 8
) (
    input  logic                       I_clk,
    input  logic                       I_reset_n,
    input  logic [4:0]                 I_opcode,
    input  logic [2:0]                 I_busop,
    input  logic [5:0]                 I_branchmask,
    input  logic                       I_alu_eq,
    input  logic                       I_alu_lt,
    input  logic                       I_alu_ltu,
    input  logic                       I_alu_busy,
    spu32_cpu_control_if.master        bus,
    output logic                       O_dec_en,
    output logic                       O_alu_en,
    output logic                       O_alu_a_sel,
    output logic                       O_alu_b_sel,
    output logic                       O_reg_we,
    output logic [1:0]                 O_rd_sel,
    output logic                       O_pc_we,
    output logic [1:0]                 O_pc_sel,
    output logic                       O_trap
);

    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST =
        TIMEOUT_W'((BUS_TIMEOUT > 0) ? BUS_TIMEOUT - 1 : 0);

    state_t               state;
    state_t               state_next;
    logic [TIMEOUT_W-1:0] wait_cnt;
    logic                 exec_started;
    logic                 flag_eq;
    logic                 flag_lt;
    logic                 flag_ltu;
    logic                 bus_req;
    logic                 timed_out;
    logic                 branch_taken;

    assign bus_req = (state == S_FETCH) || (state == S_MEM);

    // The cycle that would bring the wait count up to the limit is the last one
    // allowed; an ack in that cycle still completes the transfer.
    assign timed_out = (BUS_TIMEOUT != 0) && bus_req && !bus.bus_ack &&
                       (wait_cnt == TIMEOUT_LAST);

    spu32_cpu_branch_eval u_branch_eval (
        .branchmask (I_branchmask),
        .eq         (flag_eq),
        .lt         (flag_lt),
        .ltu        (flag_ltu),
        .taken      (branch_taken)
    );

    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            wait_cnt     <= '0;
            exec_started <= 1'b0;
            flag_eq      <= 1'b0;
            flag_lt      <= 1'b0;
            flag_ltu     <= 1'b0;
        end else begin
            if (!bus_req || bus.bus_ack || (state_next != state)) begin
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt + TIMEOUT_W'(1);
            end
            exec_started <= (state == S_EXEC);
            // Flags are frozen on the final execute cycle for use in writeback
            if ((state == S_EXEC) && !I_alu_busy) begin
                flag_eq  <= I_alu_eq;
                flag_lt  <= I_alu_lt;
                flag_ltu <= I_alu_ltu;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH: begin
                if (bus.bus_ack) begin
                    state_next = S_DECODE;
                end else if (timed_out) begin
                    state_next = S_TRAP;
                end
            end
            S_DECODE: begin
                if (!opcode_legal(I_opcode) || (I_opcode == OP_SYSTEM)) begin
                    state_next = S_TRAP;
                end else if (I_opcode == OP_MISC_MEM) begin
                    state_next = S_WB;
                end else begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (!I_alu_busy) begin
                    state_next = ((I_opcode == OP_LOAD) || (I_opcode == OP_STORE)) ? S_MEM : S_WB;
                end
            end
            S_MEM: begin
                if (bus.bus_ack) begin
                    state_next = S_WB;
                end else if (timed_out) begin
                    state_next = S_TRAP;
                end
            end
            S_WB:    state_next = S_FETCH;
            S_TRAP:  state_next = S_TRAP;
            default: state_next = S_TRAP;
        endcase
    end

    // Outputs are gated by reset directly so a reset mid-transfer drops the bus at once
    always_comb begin
        O_dec_en         = 1'b0;
        O_alu_en         = 1'b0;
        O_alu_a_sel      = ASEL_RS1;
        O_alu_b_sel      = BSEL_RS2;
        bus.bus_en       = 1'b0;
        bus.bus_op       = BUSOP_READB;
        bus.bus_addr_sel = 1'b0;
        O_reg_we         = 1'b0;
        O_rd_sel         = RDSEL_ALU;
        O_pc_we          = 1'b0;
        O_pc_sel         = PCSEL_INC;
        O_trap           = 1'b0;
        if (I_reset_n) begin
            case (state)
                S_FETCH: begin
                    bus.bus_en = 1'b1;
                    bus.bus_op = BUSOP_READW;
                    O_dec_en   = bus.bus_ack;
                end
                S_EXEC: begin
                    O_alu_en    = !exec_started;
                    O_alu_a_sel = (I_opcode == OP_AUIPC) ? ASEL_PC : ASEL_RS1;
                    O_alu_b_sel = ((I_opcode == OP_OP) || (I_opcode == OP_BRANCH)) ? BSEL_RS2 : BSEL_IMM;
                end
                S_MEM: begin
                    bus.bus_en       = 1'b1;
                    bus.bus_op       = I_busop;
                    bus.bus_addr_sel = 1'b1;
                end
                S_WB: begin
                    O_pc_we  = 1'b1;
                    O_reg_we = !((I_opcode == OP_STORE) || (I_opcode == OP_BRANCH) ||
                                 (I_opcode == OP_MISC_MEM));
                    if (I_opcode == OP_LOAD) begin
                        O_rd_sel = RDSEL_BUS;
                    end else if ((I_opcode == OP_JAL) || (I_opcode == OP_JALR)) begin
                        O_rd_sel = RDSEL_PC4;
                    end
                    if ((I_opcode == OP_JAL) || ((I_opcode == OP_BRANCH) && branch_taken)) begin
                        O_pc_sel = PCSEL_IMM;
                    end else if (I_opcode == OP_JALR) begin
                        O_pc_sel = PCSEL_ALU;
                    end
                end
                S_TRAP:  O_trap = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
